// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Word memory request/acknowledge bus between a core's data
//               memory initiator and a memory-side responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;

    logic [31:0] mem_address_i;     // byte address from initiator
    logic [31:0] mem_write_data_i;  // write data
    logic        mem_read_en_i;     // read request
    logic        mem_write_en_i;    // write request
    logic [31:0] mem_read_data_o;   // read data, held until the next read ack
    logic        mem_ack_o;         // one-cycle completion pulse
    logic        mem_busy_o;        // request accepted, not yet acknowledged
    logic        mem_err_o;         // error flag, qualified by mem_ack_o

    // Initiator side: drives the request, observes the completion
    modport master (
        output mem_address_i,
        output mem_write_data_i,
        output mem_read_en_i,
        output mem_write_en_i,
        input  mem_read_data_o,
        input  mem_ack_o,
        input  mem_busy_o,
        input  mem_err_o
    );

    // Responder side: observes the request, drives the completion
    modport slave (
        input  mem_address_i,
        input  mem_write_data_i,
        input  mem_read_en_i,
        input  mem_write_en_i,
        output mem_read_data_o,
        output mem_ack_o,
        output mem_busy_o,
        output mem_err_o
    );

endinterface : mem_responder_if
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder servicing word read/write requests from
//               an internal word-addressed RAM, with a programmable number of
//               wait states and a single-cycle acknowledge.
//               Optional feature macro: MEM_RESP_ERR_CHECK_EN
//                 defined     -> misaligned / out-of-range requests are flagged
//                                on mem_err_o, writes suppressed, reads return 0
//                 not defined -> mem_err_o tied low, low address bits ignored,
//                                upper address bits alias onto the RAM
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH_LOG2  = 10,   // log2 of RAM depth in 32-bit words
    parameter int WAIT_STATES = 2     // cycles between acceptance and ack, 0..15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_responder_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Counter preload so that exactly WAIT_STATES cycles are spent in WAIT
    localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q,   cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q,   idx_d;     // latched word index
    logic [31:0]             wdata_q, wdata_d;   // latched write data
    logic                    write_q, write_d;   // latched request type
    logic                    err_q,   err_d;     // latched error classification
    logic [31:0]             rdata_q, rdata_d;   // read data register

    logic [31:0]             ram [DEPTH];

    logic                    w_req;
    logic [DEPTH_LOG2-1:0]   w_in_idx;
    logic                    w_in_err;
    logic                    w_ram_we;

    assign w_req    = bus.mem_read_en_i | bus.mem_write_en_i;
    assign w_in_idx = bus.mem_address_i[DEPTH_LOG2+1:2];

`ifdef MEM_RESP_ERR_CHECK_EN
    // Misaligned, or addressing beyond the RAM
    assign w_in_err = (bus.mem_address_i[1:0] != 2'b00)
                   || ((bus.mem_address_i >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
    // Byte offset and upper bits deliberately ignored (aliasing)
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.mem_address_i[31:DEPTH_LOG2+2], bus.mem_address_i[1:0]};
    assign w_in_err      = 1'b0;
`endif

    // Next-state, request latching and read data capture on entry to ACK
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    // Simultaneous read and write is treated as a write
                    idx_d   = w_in_idx;
                    wdata_d = bus.mem_write_data_i;
                    write_d = bus.mem_write_en_i;
                    err_d   = w_in_err;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                        // Zero wait states: data must be ready in the very next cycle
                        if (!bus.mem_write_en_i) begin
                            rdata_d = w_in_err ? 32'h0000_0000 : ram[w_in_idx];
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = c_wait_load;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    // Load read data on the edge into ACK so it is valid with the ack
                    if (!write_q) begin
                        rdata_d = err_q ? 32'h0000_0000 : ram[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_ACK: begin
                // A mandatory IDLE cycle always follows the acknowledge
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0000_0000;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // A write commits at the end of its ACK cycle; erroneous writes are dropped
    assign w_ram_we = (state_q == ST_ACK) && write_q && !err_q;

    // RAM array, contents are not reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            ram[idx_q] <= wdata_q;
        end
    end

    assign bus.mem_read_data_o = rdata_q;
    assign bus.mem_ack_o       = (state_q == ST_ACK);
    assign bus.mem_busy_o      = (state_q != ST_IDLE);

`ifdef MEM_RESP_ERR_CHECK_EN
    assign bus.mem_err_o = (state_q == ST_ACK) && err_q;
`else
    assign bus.mem_err_o = 1'b0;
`endif

endmodule : mem_responder
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's external data memory interface. It accepts word read/write requests from the core's memory initiator port (address, write data, read enable, write enable) and services them from an internal word-addressed RAM. A parameterised wait-state counter models slow memory. Completion is signalled with a single-cycle acknowledge, so the initiator side can be driven against a realistic slave in simulation and on FPGA.

## Interface
- `DEPTH_LOG2`, default 10: log2 of RAM depth in 32-bit words (default 1024 words).
- `WAIT_STATES`, default 2: extra cycles inserted between request acceptance and acknowledge; legal range 0..15.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_address_i` in 32: byte address from initiator.
- `mem_write_data_i` in 32: write data.
- `mem_read_en_i` in 1: read request.
- `mem_write_en_i` in 1: write request.
- `mem_read_data_o` out 32: read data; valid in the ack cycle and held until the next read ack.
- `mem_ack_o` out 1: one-cycle completion pulse.
- `mem_busy_o` out 1: high while a request is accepted but not yet acknowledged.
- `mem_err_o` out 1: error flag, qualified by `mem_ack_o` (see Configuration).

## Operation
- FSM states:
  - IDLE: `busy`=0. If `read_en|write_en` is sampled, latch address, write data and type, then go to WAIT (if `WAIT_STATES`>0, counter loaded with `WAIT_STATES-1`) or ACK (if `WAIT_STATES`=0).
  - WAIT: `busy`=1; counter decrements; at 0 go to ACK.
  - ACK: `busy`=1 and `mem_ack_o`=1 for exactly one cycle. The write is committed to RAM at the end of this cycle; read data is presented. Then go to IDLE unconditionally.
- Request fields are latched at acceptance. Changes or deassertion of inputs during WAIT/ACK are ignored; a request cannot be aborted.
- Initiator must deassert or change the request in the cycle after ACK. Any request still asserted in IDLE is accepted as a new transaction.
- Read and write both asserted: treated as a write. Read data is not updated.
- Word index = `mem_address_i[DEPTH_LOG2+1:2]`.
- Read data register updates only on read acks. RAM contents are not reset.

## Timing
- Reset values: state IDLE, counter 0, `mem_read_data_o`=0, `mem_ack_o`=0, `mem_busy_o`=0, `mem_err_o`=0. Latched request registers are cleared to 0.
- Request sampled at edge N in IDLE: `mem_ack_o` is high during cycle N+1+`WAIT_STATES`. With `WAIT_STATES`=0, ack appears in the cycle after acceptance.
- Throughput: one transaction per `WAIT_STATES`+2 cycles. The mandatory IDLE cycle follows each ACK.
- Read-after-write to the same word returns the new data, because the write commits at the ACK edge before the next acceptance.
- `rst` asserted mid-transaction (WAIT or ACK):
  - Outputs clear immediately (asynchronously).
  - A pending write is discarded unless its ACK edge completed.
  - After release, the FSM starts in IDLE.

## Configuration
- `MEM_RESP_ERR_CHECK_EN` defined:
  - A request is erroneous if `addr[1:0]`≠0, or if any bit of `addr[31:DEPTH_LOG2+2]` is set.
  - Erroneous requests are still timed and acknowledged normally, with `mem_err_o`=1 in the ack cycle.
  - Erroneous writes are suppressed.
  - Erroneous reads return `32'h0000_0000`.
- `MEM_RESP_ERR_CHECK_EN` not defined:
  - `mem_err_o` is constantly 0.
  - `addr[1:0]` is ignored.
  - Upper address bits alias onto the RAM.

## Test plan
- Reset: assert `rst` for 3 cycles -> all outputs 0. Then a read request is accepted on the first edge after release.
- `WAIT_STATES`=2: write `32'hA5A5_1234` to `0x40`, then read `0x40` -> each ack arrives 3 cycles after acceptance. Read returns `32'hA5A5_1234`; `busy` is high for 3 cycles per transaction.
- Back-to-back with request held high through ACK: reads to `0x0`, `0x4` -> second acceptance occurs in the IDLE cycle after the first ack. Acks are 4 cycles apart.
- Inputs changed mid-WAIT (address `0x8`→`0xC`, `read_en` dropped) -> ack still issued. Data comes from the originally latched `0x8`.
- Reset during WAIT of a write of `32'hDEAD_0001` to `0x10`, then read `0x10` -> old content returned; no ack for the aborted write.
- With macro: write to `0x2` and read from `1<<(DEPTH_LOG2+2)` -> both acked with `mem_err_o`=1. The read returns 0 and RAM word 0 is unchanged. Without macro: the same read aliases word 0 and `mem_err_o`=0.
